wr_burst_ctrl: RTL and testbench
================================

WR_BURST_CTRL -- requirements
Module: wr_burst_ctrl

Interface
REQ-001 The module SHALL have the following parameters:
- ADDR_SIZE, default 4: FIFO address width.
- DATA_SIZE, default 8: word width.
- LEN_SIZE, default 8: burst-length width.
- AFULL_THRESH, default 12: almost-full level.

REQ-002 The module SHALL have the following ports, clock and reset first:
- wclk  in  1  write-domain clock; one clock only.
- wrst  in  1  reset, asynchronous, active-high.
- start  in  1  burst request, sampled in IDLE only.
- burst_len  in  LEN_SIZE  words in the burst, captured with start.
- s_valid  in  1  source word valid.
- s_data  in  DATA_SIZE  source word.
- s_ready  out  1  source word accepted when s_valid and s_ready are both high.
- wfull  in  1  FIFO full flag from the write-pointer stage.
- wptr  in  ADDR_SIZE+1  Gray write pointer from the write-pointer stage.
- wq2_rptr  in  ADDR_SIZE+1  synchronized Gray read pointer.
- winc  out  1  FIFO write enable.
- wdata  out  DATA_SIZE  FIFO write data.
- busy  out  1  burst in progress.
- done  out  1  one-cycle burst-complete pulse.
- words_written  out  LEN_SIZE  words written in the current or last burst.
- wlevel  out  ADDR_SIZE+1  FIFO fill level seen from the write side.
- walmost_full  out  1  high when wlevel >= AFULL_THRESH.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WRITE and DONE.
REQ-004 In IDLE, start=1 with burst_len!=0 SHALL load remaining=burst_len, clear words_written and enter WRITE on the next edge.
REQ-005 In IDLE, start=1 with burst_len==0 SHALL enter DONE directly, with words_written=0 and no winc.
REQ-006 start SHALL be ignored in WRITE and DONE; it is not queued.
REQ-007 winc SHALL equal (state==WRITE) & s_valid & ~wfull, combinationally.
REQ-008 s_ready SHALL equal (state==WRITE) & ~wfull, combinationally.
REQ-009 wdata SHALL equal s_data combinationally, so zero-latency pass-through with no buffering.
REQ-010 Each winc cycle SHALL decrement remaining by 1 and increment words_written by 1.
REQ-011 When winc=1 and remaining==1, the FSM SHALL enter DONE on the next edge.
REQ-012 No winc SHALL occur after the final word of a burst.
REQ-013 With wfull=1, winc and s_ready SHALL stay 0 and the FSM SHALL hold WRITE indefinitely with counters frozen.
REQ-014 When wfull deasserts, writing SHALL resume on that same cycle.
REQ-015 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-016 A start in the cycle after DONE SHALL be accepted, so back-to-back bursts are possible.
REQ-017 busy SHALL be 1 in WRITE and DONE and 0 in IDLE.
REQ-018 words_written SHALL hold its value in IDLE until the next accepted start.
REQ-019 wlevel SHALL be registered as (gray2bin(wptr) - gray2bin(wq2_rptr)) mod 2^(ADDR_SIZE+1), with a valid range of 0..2^ADDR_SIZE.
REQ-020 walmost_full SHALL be a register computed from the same-cycle next value of wlevel, so it has one cycle of latency from the pointers, the same as wlevel.
REQ-021 Pointer wrap (MSB toggle) SHALL yield a correct wlevel; for example, wptr bin 17 with rptr bin 30 at ADDR_SIZE=4 gives level 19 mod 32, which is an illegal value that the upstream stage never produces, and the level SHALL be computed modulo only.

Reset
REQ-022 Asserting wrst SHALL immediately force state=IDLE, remaining=0, words_written=0, wlevel=0, walmost_full=0 and done=0, without waiting for a wclk edge.
REQ-023 While wrst=1, winc, s_ready and busy SHALL be 0.
REQ-024 Reset in mid-burst SHALL abandon the burst with no done pulse.
REQ-025 Leaving reset SHALL take effect on the first wclk edge after wrst falls.

Configuration
REQ-026 The macro WR_BURST_ABORT_EN SHALL control an abort feature.
REQ-027 With WR_BURST_ABORT_EN defined, an input port abort (1 bit) SHALL exist.
REQ-028 With WR_BURST_ABORT_EN defined, abort=1 in WRITE SHALL force winc=0 and s_ready=0 that cycle and enter DONE next edge, with words_written showing the words actually written.
REQ-029 With WR_BURST_ABORT_EN defined, abort SHALL be ignored in IDLE and DONE.
REQ-030 With WR_BURST_ABORT_EN undefined, the abort port SHALL be absent and bursts end only by count or by reset.

Verification
REQ-031 Length-4 burst, s_valid steady, wfull=0: start, burst_len=4 -> winc high for exactly 4 cycles, done pulses 1 cycle later, words_written=4.
REQ-032 Stall during burst: burst_len=6 with wfull=1 after 2 words for 5 cycles -> winc=0 during the stall, 6 total writes, words_written=6, done exactly once.
REQ-033 Zero-length burst: start with burst_len=0 -> winc never high, done 1 cycle after start, words_written=0.
REQ-034 Level and almost-full, ADDR_SIZE=4: wptr=gray(13), wq2_rptr=gray(1) -> wlevel=12 and walmost_full=1 one cycle later; then wq2_rptr=gray(2) -> wlevel=11 and walmost_full=0.
REQ-035 Level across wrap: wptr=gray(3), wq2_rptr=gray(28) -> wlevel=7.
REQ-036 Reset mid-burst, and abort when compiled in: wrst asserted after 2 of 8 words -> winc, busy and words_written drop to 0 asynchronously with no done; with WR_BURST_ABORT_EN, abort after 3 of 8 words -> done next cycle, words_written=3.

Source files
------------

// File: rtl/wr_burst_ctrl.sv
// Write-side burst controller: passes a counted burst of source words into an async FIFO.
// Define WR_BURST_ABORT_EN to add the abort input that ends a burst early.
module wr_burst_ctrl #(
    parameter int unsigned ADDR_SIZE    = 4,
    parameter int unsigned DATA_SIZE    = 8,
    parameter int unsigned LEN_SIZE     = 8,
    parameter int unsigned AFULL_THRESH = 12
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 start,
    input  logic [LEN_SIZE-1:0]  burst_len,
    input  logic                 s_valid,
    input  logic [DATA_SIZE-1:0] s_data,
    output logic                 s_ready,
    input  logic                 wfull,
    input  logic [ADDR_SIZE:0]   wptr,
    input  logic [ADDR_SIZE:0]   wq2_rptr,
`ifdef WR_BURST_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 winc,
    output logic [DATA_SIZE-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic [LEN_SIZE-1:0]  words_written,
    output logic [ADDR_SIZE:0]   wlevel,
    output logic                 walmost_full
);

    localparam int unsigned LvlW = ADDR_SIZE + 1;
    localparam logic [LvlW-1:0] AfullLvl = LvlW'(AFULL_THRESH);

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_t;

    state_t              state;
    logic [LEN_SIZE-1:0] remaining;
    logic                abort_hit;
    logic [LvlW-1:0]     wlevel_next;

`ifdef WR_BURST_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    function automatic logic [LvlW-1:0] gray2bin(input logic [LvlW-1:0] g);
        logic [LvlW-1:0] b;
        for (int i = 0; i < LvlW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Source handshake is purely combinational so a word moves straight through.
    assign s_ready = (state == StWrite) & ~wfull & ~abort_hit;
    assign winc    = s_ready & s_valid;
    assign wdata   = s_data;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state         <= StIdle;
            remaining     <= '0;
            words_written <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        words_written <= '0;
                        busy          <= 1'b1;
                        if (burst_len != '0) begin
                            remaining <= burst_len;
                            state     <= StWrite;
                        end else begin
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StWrite: begin
                    if (abort_hit) begin
                        done  <= 1'b1;
                        state <= StDone;
                    end else if (winc) begin
                        remaining     <= remaining - LEN_SIZE'(1);
                        words_written <= words_written + LEN_SIZE'(1);
                        if (remaining == LEN_SIZE'(1)) begin
                            done  <= 1'b1;
                            state <= StDone;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

    // Level wraps modulo the pointer width; out-of-range values are passed through as-is.
    assign wlevel_next = gray2bin(wptr) - gray2bin(wq2_rptr);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= wlevel_next;
            walmost_full <= (wlevel_next >= AfullLvl);
        end
    end

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Randomized scoreboard bench for wr_burst_ctrl; abort checks build only with WR_BURST_ABORT_EN.
module tb_wr_burst_ctrl;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LW = 8;

    logic          wclk, wrst, start, s_valid, s_ready, wfull, winc, busy, done, walmost_full;
    logic [LW-1:0] burst_len, words_written;
    logic [DW-1:0] s_data, wdata;
    logic [AW:0]   wptr, wq2_rptr, wlevel;
`ifdef WR_BURST_ABORT_EN
    logic          abort;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int last_count = 0;
    int prev_level = 0;

    logic [DW-1:0] exp_q[$];
    int            done_q[$];

    logic [DW-1:0] rsrc[8];
    int            ridx;
    bit            racc;

    wr_burst_ctrl #(
        .ADDR_SIZE(AW), .DATA_SIZE(DW), .LEN_SIZE(LW), .AFULL_THRESH(12)
    ) dut (
        .wclk(wclk), .wrst(wrst), .start(start), .burst_len(burst_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .wfull(wfull),
        .wptr(wptr), .wq2_rptr(wq2_rptr),
`ifdef WR_BURST_ABORT_EN
        .abort(abort),
`endif
        .winc(winc), .wdata(wdata), .busy(busy), .done(done),
        .words_written(words_written), .wlevel(wlevel), .walmost_full(walmost_full)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] x;
        x = b[AW:0];
        return x ^ (x >> 1);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT writes or signals completion.
    always @(negedge wclk) begin
        if (!wrst) begin
            if (wfull) begin
                chk("s_ready_while_full", s_ready, 0);
                chk("winc_while_full", winc, 0);
            end
            chk("winc_handshake", winc, s_valid & s_ready);
            if (winc) begin
                if (exp_q.size() == 0) chk("unexpected_winc", winc, 0);
                else chk("wdata", wdata, exp_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", done, 0);
                else chk("words_written_at_done", words_written, done_q.pop_front());
                chk("busy_at_done", busy, 1);
            end
        end
    end

    // Entered and left at posedge+1; expected words/count go to the scoreboard up front.
    task automatic run_burst(input int len, input bit steady, input int abort_at);
        logic [DW-1:0] src[$];
        int idx, cyc, n_exp;
        bit acc, fin, aborted;
        idx = 0; cyc = 0; fin = 0; aborted = 0;
        for (int i = 0; i < len; i++) src.push_back(DW'($urandom));
        n_exp = (abort_at >= 0) ? abort_at : len;
        for (int i = 0; i < n_exp; i++) exp_q.push_back(src[i]);
        done_q.push_back(n_exp);
        start = 1'b1;
        burst_len = LW'(len);
        s_valid = steady ? 1'b1 : ($urandom_range(3) != 0);
        wfull = steady ? 1'b0 : ($urandom_range(3) == 0);
        if (idx < len) s_data = src[idx];
        else s_data = DW'($urandom);
        while (!fin && cyc < 300) begin
            @(negedge wclk);
            if (cyc == 0) begin
                chk("idle_busy", busy, 0);
                chk("idle_hold_count", words_written, last_count);
            end
            if (cyc == 1 && len > 0) chk("write_busy", busy, 1);
`ifdef WR_BURST_ABORT_EN
            if (abort) chk("abort_sready", s_ready, 0);
`endif
            acc = s_valid & s_ready;
            fin = done;
            if (fin && steady) chk("done_latency", cyc, (abort_at >= 0) ? abort_at + 2 : len + 1);
            @(posedge wclk);
            #1;
            cyc++;
            if (acc) idx++;
            if (fin || steady) start = 1'b0;
            else begin
                start = ($urandom_range(3) == 0);
                burst_len = LW'($urandom);
            end
`ifdef WR_BURST_ABORT_EN
            abort = (abort_at >= 0 && !aborted && idx == abort_at);
            if (abort) aborted = 1;
`endif
            s_valid = steady ? 1'b1 : ($urandom_range(3) != 0);
            wfull = steady ? 1'b0 : ($urandom_range(3) == 0);
            if (idx < len) s_data = src[idx];
            else s_data = DW'($urandom);
        end
        start = 1'b0;
        if (!fin) begin
            chk("burst_timeout", fin, 1);
            exp_q.delete();
            done_q.delete();
        end
        last_count = n_exp;
    endtask

    task automatic set_ptrs(input int wb, input int rb);
        int lvl;
        lvl = (wb - rb) & 31;
        wptr = gray(wb);
        wq2_rptr = gray(rb);
        @(negedge wclk);
        chk("level_latency", wlevel, prev_level);
        @(negedge wclk);
        chk("wlevel", wlevel, lvl);
        chk("walmost_full", walmost_full, lvl >= 12);
        prev_level = lvl;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        wrst = 1'b1; start = 1'b0; burst_len = '0; s_valid = 1'b0; s_data = '0;
        wfull = 1'b0; wptr = '0; wq2_rptr = '0;
`ifdef WR_BURST_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_winc", winc, 0);
        chk("rst_words", words_written, 0);
        chk("rst_wlevel", wlevel, 0);
        chk("rst_afull", walmost_full, 0);
        #11 wrst = 1'b0;
        @(posedge wclk);
        #1;

        set_ptrs(13, 1);
        set_ptrs(13, 2);
        set_ptrs(3, 28);
        set_ptrs(17, 30);
        for (int i = 0; i < 16; i++) set_ptrs($urandom_range(31), $urandom_range(31));

        run_burst(4, 1, -1);
        run_burst(0, 1, -1);
        run_burst(6, 0, -1);
        for (int i = 0; i < 12; i++) run_burst($urandom_range(12), $urandom_range(1), -1);
`ifdef WR_BURST_ABORT_EN
        run_burst(8, 1, 3);
        run_burst(5, 0, -1);
`endif

        // Reset two words into an eight-word burst.
        set_ptrs(13, 1);
        for (int i = 0; i < 8; i++) rsrc[i] = DW'($urandom);
        for (int i = 0; i < 8; i++) exp_q.push_back(rsrc[i]);
        done_q.push_back(8);
        start = 1'b1; burst_len = 8; s_valid = 1'b1; wfull = 1'b0; ridx = 0; s_data = rsrc[0];
        for (int c = 0; c < 3; c++) begin
            @(negedge wclk);
            racc = s_valid & s_ready;
            @(posedge wclk);
            #1;
            start = 1'b0;
            if (racc) ridx++;
            s_data = rsrc[ridx];
        end
        chk("pre_reset_count", words_written, 2);
        #3 wrst = 1'b1;
        #1;
        chk("async_rst_winc", winc, 0);
        chk("async_rst_sready", s_ready, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_words", words_written, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_wlevel", wlevel, 0);
        chk("async_rst_afull", walmost_full, 0);
        exp_q.delete();
        done_q.delete();
        @(negedge wclk);
        chk("in_rst_winc", winc, 0);
        @(posedge wclk);
        #2 wrst = 1'b0;
        s_valid = 1'b0;
        last_count = 0;
        @(negedge wclk);
        chk("level_before_first_edge", wlevel, 0);
        @(negedge wclk);
        chk("level_after_first_edge", wlevel, prev_level);
        chk("post_rst_busy", busy, 0);
        @(posedge wclk);
        #1;

        run_burst(3, 1, -1);
        run_burst(7, 0, -1);
        s_valid = 1'b1;
        repeat (4) @(posedge wclk);
        @(negedge wclk);
        chk("data_queue_drained", exp_q.size(), 0);
        chk("done_queue_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
